// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// frame-format defaults that the transmit side also picks up.
package uart_rx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_t;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;
  localparam int DEF_OVS     = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_sync.sv
// Single-bit two-flop synchronizer with a selectable synchronous reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: samples start/data/stop bits at the middle of each
// bit using a 16x oversampling strobe and delivers one parallel word per frame.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int OVS     = DEF_OVS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            busy
);

  localparam int SW = $clog2(max2(OVS, SB_TICK));
  localparam int NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  rx_state_t       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_d;
  logic            ferr_d;
  logic            done_d;
  logic            rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      dout         <= dout_d;
      frame_err    <= ferr_d;
      rx_done_tick <= done_d;
      busy         <= (state_d != IDLE);
    end
  end

  // Start is re-checked at mid-bit so a short low glitch is dropped silently.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout;
    ferr_d  = frame_err;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            state_d = IDLE;
            dout_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: an 8N1 instance and a 7-bit/2-stop
// instance share one oversampling strobe; completed frames are scoreboarded.
module tb_uart_rx_ctrl;

  localparam int DIV     = 5;
  localparam int OVS     = 16;
  localparam int BIT_CLK = DIV * OVS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  logic [7:0] dout_a;
  logic       done_a, ferr_a, busy_a;
  logic [6:0] dout_b;
  logic       done_b, ferr_b, busy_b;

  int tests = 0;
  int fails = 0;
  int div_cnt = 0;
  int tick_count = 0;
  int t0 = 0;
  int done_tick_a = 0, done_tick_b = 0;
  int done_cnt_a = 0, done_cnt_b = 0;
  int push_cnt_a = 0, push_cnt_b = 0;
  int lat;

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    int         gap;
    logic [7:0] exp_dout;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (div_cnt == DIV - 1) begin
      div_cnt <= 0;
      s_tick  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1;
      s_tick  <= 1'b0;
    end
    if (s_tick) tick_count <= tick_count + 1;
  end

  uart_rx_ctrl #(.DBIT(8), .SB_TICK(16), .OVS(16)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_a),
    .s_tick       (s_tick),
    .dout         (dout_a),
    .rx_done_tick (done_a),
    .frame_err    (ferr_a),
    .busy         (busy_a)
  );

  uart_rx_ctrl #(.DBIT(7), .SB_TICK(32), .OVS(16)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_b),
    .s_tick       (s_tick),
    .dout         (dout_b),
    .rx_done_tick (done_b),
    .frame_err    (ferr_b),
    .busy         (busy_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Each done pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (!reset && done_a) begin
      done_cnt_a++;
      done_tick_a = tick_count;
      checkOutput("pending_frame_a", (q_a.size() != 0), 1);
      if (q_a.size() != 0) begin
        automatic logic [8:0] w = q_a.pop_front();
        checkOutput("dout_a", dout_a, w[7:0]);
        checkOutput("frame_err_a", ferr_a, w[8]);
      end
    end
    if (!reset && done_b) begin
      done_cnt_b++;
      done_tick_b = tick_count;
      checkOutput("pending_frame_b", (q_b.size() != 0), 1);
      if (q_b.size() != 0) begin
        automatic logic [8:0] w = q_b.pop_front();
        checkOutput("dout_b", dout_b, w[6:0]);
        checkOutput("frame_err_b", ferr_b, w[8]);
      end
    end
  end

  task automatic drive_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  function automatic logic busy_of(input int which);
    return (which == 0) ? busy_a : busy_b;
  endfunction

  // Called on a falling clock edge; returns on a falling clock edge.
  task automatic applyStimulus(input int which, input int nbits, input logic [8:0] data,
                               input logic stop_ok, input int stop_bits, input int gap_bits,
                               input logic check_busy, input logic [8:0] exp_word);
    logic busy_ok;
    busy_ok = 1'b1;
    if (which == 0) begin
      q_a.push_back(exp_word);
      push_cnt_a++;
    end else begin
      q_b.push_back(exp_word);
      push_cnt_b++;
    end
    t0 = tick_count;
    for (int i = 0; i <= nbits; i++) begin
      drive_rx(which, (i == 0) ? 1'b0 : data[i-1]);
      repeat (BIT_CLK / 2) @(negedge clk);
      if (busy_of(which) !== 1'b1) busy_ok = 1'b0;
      repeat (BIT_CLK - BIT_CLK / 2) @(negedge clk);
    end
    if (stop_ok) begin
      drive_rx(which, 1'b1);
      repeat (stop_bits * BIT_CLK) @(negedge clk);
    end else begin
      drive_rx(which, 1'b0);
      repeat ((stop_bits - 1) * BIT_CLK + BIT_CLK / 2 + 2 * DIV) @(negedge clk);
      drive_rx(which, 1'b1);
      repeat (BIT_CLK / 2 - 2 * DIV) @(negedge clk);
    end
    repeat (gap_bits * BIT_CLK) @(negedge clk);
    if (check_busy) begin
      checkOutput("busy_during_frame", busy_ok, 1'b1);
      checkOutput("busy_after_frame", busy_of(which), 1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'h00, stop_ok: 1'b1, gap: 0, exp_dout: 8'h00, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'hFF, stop_ok: 1'b1, gap: 1, exp_dout: 8'hFF, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'h3C, stop_ok: 1'b0, gap: 1, exp_dout: 8'h3C, exp_ferr: 1'b1};
    vecs[3] = '{data: 8'h55, stop_ok: 1'b1, gap: 1, exp_dout: 8'h55, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'h00, stop_ok: 1'b0, gap: 1, exp_dout: 8'h00, exp_ferr: 1'b1};
    vecs[5] = '{data: 8'h81, stop_ok: 1'b1, gap: 1, exp_dout: 8'h81, exp_ferr: 1'b0};

    reset = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("reset_dout_a", dout_a, 8'h00);
    checkOutput("reset_busy_a", busy_a, 1'b0);
    checkOutput("reset_ferr_a", ferr_a, 1'b0);
    checkOutput("reset_done_a", done_a, 1'b0);
    checkOutput("reset_dout_b", dout_b, 7'h00);
    reset = 1'b0;
    repeat (2 * BIT_CLK) @(negedge clk);
    checkOutput("idle_busy_a", busy_a, 1'b0);

    applyStimulus(0, 8, 9'h0A5, 1'b1, 1, 0, 1'b1, {1'b0, 8'hA5});
    lat = done_tick_a - t0;
    if (lat < 152 || lat > 153) $display("[TB] latency_a measured %0d ticks", lat);
    checkOutput("latency_a_in_window", (lat >= 152 && lat <= 153), 1);
    repeat (BIT_CLK) @(negedge clk);

    rx_a = 1'b0;
    repeat (2 * DIV + 2) @(negedge clk);
    checkOutput("glitch_busy_a", busy_a, 1'b1);
    repeat (DIV - 2) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    checkOutput("glitch_busy_after", busy_a, 1'b0);
    checkOutput("glitch_dout_kept", dout_a, 8'hA5);
    checkOutput("glitch_no_done", done_cnt_a, 1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 8, {1'b0, vecs[i].data}, vecs[i].stop_ok, 1, vecs[i].gap, 1'b0,
                    {vecs[i].exp_ferr, vecs[i].exp_dout});
    end

    // Abort 0x81 halfway through data bit 4.
    rx_a = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_a = (i == 0) ? 1'b1 : 1'b0;
      repeat (BIT_CLK) @(negedge clk);
    end
    rx_a = 1'b0;
    repeat (BIT_CLK / 2) @(negedge clk);
    checkOutput("mid_frame_busy", busy_a, 1'b1);
    reset = 1'b1;
    rx_a  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_mid_busy", busy_a, 1'b0);
    checkOutput("reset_mid_dout", dout_a, 8'h00);
    checkOutput("reset_mid_ferr", ferr_a, 1'b0);
    repeat (12 * BIT_CLK) @(negedge clk);
    checkOutput("reset_mid_dout_held", dout_a, 8'h00);
    checkOutput("reset_mid_no_done", done_cnt_a, 7);
    applyStimulus(0, 8, 9'h081, 1'b1, 1, 1, 1'b1, {1'b0, 8'h81});

    applyStimulus(1, 7, 9'h05A, 1'b1, 2, 1, 1'b1, {1'b0, 8'h5A});
    lat = done_tick_b - t0;
    if (lat < 152 || lat > 153) $display("[TB] latency_b measured %0d ticks", lat);
    checkOutput("latency_b_in_window", (lat >= 152 && lat <= 153), 1);

    repeat (2 * BIT_CLK) @(negedge clk);
    checkOutput("queue_a_drained", q_a.size(), 0);
    checkOutput("queue_b_drained", q_b.size(), 0);
    checkOutput("done_count_a", done_cnt_a, push_cnt_a);
    checkOutput("done_count_b", done_cnt_b, push_cnt_b);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
